// File: rtl/fifo_pkg.sv
`default_nettype none
// fifo_pkg: types shared by the 8-deep byte FIFO, its writer and the stream reader.
package fifo_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// skid_buffer: small circular buffer with occupancy count; push and pop may coincide.
module skid_buffer #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// fifo_stream_reader: drains the byte FIFO into a valid/ready stream through a credit-checked skid buffer.
module fifo_stream_reader #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_d_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_count
);

  import fifo_pkg::*;

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam logic [OCC_W:0] DEPTH_LIMIT = (OCC_W + 1)'(SKID_DEPTH);

  reader_state_t    state;
  logic             inflight;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   pending;

  // Credit counts the byte already requested but not yet captured, so m_ready never reaches fifo_r_en.
  assign pending   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_r_en = !rst && enable && !fifo_empty && (pending < DEPTH_LIMIT) && (state != DRAIN);

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign busy    = inflight || m_valid;

  skid_buffer #(
    .DEPTH (SKID_DEPTH),
    .W     (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_d_out),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      byte_count <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (pop) begin
        byte_count <= byte_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) state <= busy ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (!busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// tb_fifo_stream_reader: behavioural FIFO model feeds the reader; a monitor scoreboards every handshake.
module tb_fifo_stream_reader;

  import fifo_pkg::*;

  localparam int SKID_DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic        m_valid;
  logic        busy;
  byte_t       fifo_d_out = '0;
  byte_t       m_data;
  logic [15:0] byte_count;

  byte_t       mem [256];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  byte_t       exp_q [$];
  int          n_vec = 0;
  int          n_fail = 0;

  int          base_rd;
  logic [15:0] base_cnt;
  logic [11:0] ren_hist;
  logic [11:0] val_hist;
  int          ren_n;
  int          val_n;
  int          hold_n;

  assign fifo_empty = (wr_cnt == rd_cnt);

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_W     (8),
    .SKID_DEPTH (SKID_DEPTH),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_d_out (fifo_d_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .byte_count (byte_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load(input byte_t b);
    mem[wr_cnt % 256] = b;
    exp_q.push_back(b);
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || !fifo_empty) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
    check({name, "_busy"}, {31'd0, busy}, 0);
  endtask

  task automatic stream_bytes(input int count);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < count && cyc < 2 * count + 100) begin
      if (wr_cnt - rd_cnt < 8) begin
        load(byte_t'(sent));
        sent++;
      end
      step();
      cyc++;
    end
    check("stream_sent", 32'(sent), 32'(count));
  endtask

  // Registered-read FIFO: data appears the cycle after fifo_r_en.
  task automatic fifo_model();
    forever begin
      @(posedge clk);
      if (fifo_r_en) begin
        if (wr_cnt == rd_cnt) begin
          n_fail++;
          $display("FAIL underflow: fifo_r_en=1 while fifo_empty=1");
        end
        fifo_d_out <= mem[rd_cnt % 256];
        rd_cnt     <= rd_cnt + 1;
      end
    end
  endtask

  task automatic monitor();
    logic  pv;
    logic  pr;
    byte_t pd;
    byte_t e;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && (!m_valid || m_data !== pd)) begin
          n_fail++;
          $display("FAIL hold: m_valid=%0b m_data=0x%0h, required 1/0x%0h", m_valid, m_data, pd);
        end
        if (dut.inflight && int'(dut.occ) >= SKID_DEPTH) begin
          n_fail++;
          $display("FAIL overflow: capture with occ=%0d, required < %0d", dut.occ, SKID_DEPTH);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL stream: got 0x%0h, required no byte", m_data);
          end else begin
            e = exp_q.pop_front();
            check("stream", {24'd0, m_data}, {24'd0, e});
          end
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
      end
    end
  endtask

  initial begin
    fork
      fifo_model();
      monitor();
    join_none

    // Reset values
    repeat (3) step();
    sample();
    check("rst_r_en", {31'd0, fifo_r_en}, 0);
    check("rst_valid", {31'd0, m_valid}, 0);
    check("rst_data", {24'd0, m_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_count", {16'd0, byte_count}, 0);
    check("rst_state", {30'd0, dut.state}, {30'd0, IDLE});
    step();
    rst = 1'b0;

    // Single byte: read at t, valid at t+2
    base_rd = rd_cnt;
    load(8'hA5);
    enable  = 1'b1;
    m_ready = 1'b1;
    sample();
    check("single_ren_t0", {31'd0, fifo_r_en}, 1);
    sample();
    check("single_ren_t1", {31'd0, fifo_r_en}, 0);
    check("single_valid_t1", {31'd0, m_valid}, 0);
    sample();
    check("single_valid_t2", {31'd0, m_valid}, 1);
    repeat (3) step();
    check("single_count", {16'd0, byte_count}, 1);
    check("single_busy", {31'd0, busy}, 0);
    check("single_reads", 32'(rd_cnt - base_rd), 1);

    // Full burst: eight back-to-back reads, eight back-to-back outputs
    base_cnt = byte_count;
    for (int i = 1; i <= 8; i++) load(byte_t'(i));
    for (int c = 0; c < 12; c++) begin
      sample();
      ren_hist[c] = fifo_r_en;
      val_hist[c] = m_valid;
    end
    check("burst_ren", {20'd0, ren_hist}, 32'h0FF);
    check("burst_valid", {20'd0, val_hist}, 32'h3FC);
    step();
    check("burst_count", {16'd0, byte_count - base_cnt}, 8);

    // Back-pressure: only SKID_DEPTH reads, head byte held
    m_ready  = 1'b0;
    base_rd  = rd_cnt;
    base_cnt = byte_count;
    for (int i = 1; i <= 8; i++) load(byte_t'(i));
    hold_n = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (m_valid && m_data == 8'h01) hold_n++;
    end
    check("bp_reads", 32'(rd_cnt - base_rd), 3);
    check("bp_hold", 32'(hold_n), 8);
    check("bp_ren_low", {31'd0, fifo_r_en}, 0);
    step();
    m_ready = 1'b1;
    sample();
    check("bp_ren_pop_cycle", {31'd0, fifo_r_en}, 0);
    sample();
    check("bp_ren_resume", {31'd0, fifo_r_en}, 1);
    wait_drain("bp_drain", 60);
    check("bp_count", {16'd0, byte_count - base_cnt}, 8);

    // Empty guard
    ren_n = 0;
    val_n = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      ren_n += int'(fifo_r_en);
      val_n += int'(m_valid);
    end
    check("empty_ren", 32'(ren_n), 0);
    check("empty_valid", 32'(val_n), 0);

    // Enable drop with one read in flight
    step();
    base_rd = rd_cnt;
    for (int i = 0; i < 4; i++) load(byte_t'(8'h10 + i));
    sample();
    check("drop_ren_t0", {31'd0, fifo_r_en}, 1);
    step();
    enable = 1'b0;
    sample();
    check("drop_ren_t1", {31'd0, fifo_r_en}, 0);
    step();
    sample();
    check("drop_state", {30'd0, dut.state}, {30'd0, DRAIN});
    repeat (4) step();
    check("drop_reads", 32'(rd_cnt - base_rd), 1);
    check("drop_idle", {30'd0, dut.state}, {30'd0, IDLE});
    check("drop_busy", {31'd0, busy}, 0);
    check("drop_left", 32'(exp_q.size()), 3);
    enable = 1'b1;
    wait_drain("drop_rest", 60);

    // Reset during a back-pressured burst: the three fetched bytes are lost
    m_ready = 1'b0;
    base_rd = rd_cnt;
    for (int i = 0; i < 8; i++) load(byte_t'(8'h20 + i));
    repeat (6) step();
    check("rstbp_reads", 32'(rd_cnt - base_rd), 3);
    rst = 1'b1;
    step();
    sample();
    check("rstbp_r_en", {31'd0, fifo_r_en}, 0);
    check("rstbp_valid", {31'd0, m_valid}, 0);
    check("rstbp_data", {24'd0, m_data}, 0);
    check("rstbp_busy", {31'd0, busy}, 0);
    check("rstbp_count", {16'd0, byte_count}, 0);
    check("rstbp_state", {30'd0, dut.state}, {30'd0, IDLE});
    repeat (3) void'(exp_q.pop_front());
    step();
    rst     = 1'b0;
    m_ready = 1'b1;
    wait_drain("rstbp_rest", 60);
    check("rstbp_count_after", {16'd0, byte_count}, 5);

    // Counter wrap
    stream_bytes(65530);
    wait_drain("wrap_fill", 100);
    check("cnt_max", {16'd0, byte_count}, 32'hFFFF);
    stream_bytes(1);
    wait_drain("wrap_last", 100);
    check("cnt_wrap", {16'd0, byte_count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
